serial_word_capture: RTL and testbench
======================================

Name: serial_word_capture

Overview:
- Receive-side counterpart of the constant-word serializer: it assembles a serial bit stream, one bit per enabled cycle, into a parallel word.
- An internal position counter indexes the bit slot being filled, mirroring the transmitter's position chain.
- A completed word is presented on a held output register with a valid/acknowledge handshake and sticky overrun detection.
- Sits between the serial link and the parallel consumer logic.

Parameters:
- WIDTH, 32, word length in bits; legal range 2..64.
- CW, clog2(WIDTH), width of the position counter; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock; the only clock.
- clear  input  1  synchronous, active-high reset; priority over all other inputs.
- x  input  1  bit-enable: the bit on d is valid this cycle and the position advances.
- d  input  1  serial data bit, sampled only when x=1.
- ack  input  1  consumer acknowledge of the current word; meaningful only while w=1.
- q  output  WIDTH  last completed word; the first received bit lands in q[0] (LSB first).
- w  output  1  word valid; set on completion, held until acknowledged.
- z  output  1  sticky overrun flag.
- count  output  CW  current bit position, 0..WIDTH-1.

Behaviour:
- Registers: acc[WIDTH-1:0] (assembly), idx[CW-1:0] (position), q, w, z. All update on the rising clock edge only.
- Reset (clear=1 at an edge) forces acc=0, idx=0, q=0, w=0, z=0.
  - x, d and ack are ignored that cycle.
  - Clear mid-word discards the partial word.
- x=0: idx and acc hold. The handshake still runs: ack=1 with w=1 clears w.
- x=1 with idx < WIDTH-1: acc[idx] <= d; idx <= idx+1.
- x=1 with idx == WIDTH-1 (completion):
  - q <= {d, acc[WIDTH-2:0]}.
  - acc <= 0.
  - idx <= 0 (wrap).
  - w <= 1.
- Latency: a completed word appears on q with w=1 in the cycle after the edge that sampled its last bit.
- Handshake:
  - w=1 and ack=1, no completion this cycle: w <= 0; q holds its value.
  - Completion with w=0: normal case, z unchanged.
  - Completion with w=1 and ack=1 in the same cycle: the old word is consumed. New q loaded, w stays 1, z unchanged.
  - Completion with w=1 and ack=0: overrun. New q overwrites the old word, w stays 1, z <= 1.
  - ack while w=0: no effect.
- Overrun flag: z, once set, stays set until clear. It is never cleared by ack.
- q changes only on completion or clear. Partial assembly is never visible on q.
- count always equals idx, so count = number of bits already received in the current word.
- The block has no back-pressure on the serial side: bits are always accepted when x=1.

Test Plan:
- Reset: hold clear=1 for 2 cycles with x=1 and d toggling -> q=0, w=0, z=0, count=0.
- Continuous stream (WIDTH=32): x=1 for 32 cycles carrying 0xA5C30F01 LSB first, ack=0.
  - Expect count 0..31, then 0.
  - w=1 and q=0xA5C30F01 in the cycle after the 32nd bit edge; z=0.
- Gapped stream: the same word with x=1 only on alternate cycles.
  - count holds during x=0 cycles.
  - Identical q=0xA5C30F01 after 32 enabled cycles; completion takes 63 clocks.
- Handshake and overrun:
  - Pulse ack one cycle while w=1 -> w=0 next cycle, q retained.
  - Send 0x0000FFFF and leave it unacknowledged, then send 0x12345678 with ack=0 throughout -> q=0x12345678, w=1, z=1.
  - A later ack clears w; z remains 1 until clear.
- Simultaneous: assert ack in the exact cycle the last bit of 0xDEADBEEF is sampled, with the previous word still valid -> q=0xDEADBEEF, w=1, z=0.
- Clear mid-word: assert clear after 17 bits (count=17) -> count=0, q and w cleared. The next 32 bits of 0x80000001 yield q=0x80000001 with no residue from the aborted word.

Source files
------------

// File: rtl/serial_word_capture_if.sv
// Serial-in / parallel-out bundle for serial_word_capture.
// The master side drives the serial bits and acknowledge. The slave side returns the captured word.
interface serial_word_capture_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic             x;
    logic             d;
    logic             ack;
    logic [WIDTH-1:0] q;
    logic             w;
    logic             z;
    logic [CW-1:0]    count;

    modport master (
        output x,
        output d,
        output ack,
        input  q,
        input  w,
        input  z,
        input  count
    );

    modport slave (
        input  x,
        input  d,
        input  ack,
        output q,
        output w,
        output z,
        output count
    );
endinterface

// File: rtl/serial_word_capture.sv
// Assembles an LSB-first serial stream into WIDTH-bit words.
// Each completed word is held on q under a valid/ack handshake with a sticky overrun flag.
module serial_word_capture #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clock,
    input logic                  clear,
    serial_word_capture_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_acc_q, r_acc_d;
    logic [CW-1:0]    r_idx_q, r_idx_d;
    logic [WIDTH-1:0] r_q_q, r_q_d;
    logic             r_w_q, r_w_d;
    logic             r_z_q, r_z_d;
    logic             w_last;

    assign w_last = bus.x && (r_idx_q == CW'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (clear) begin
            r_acc_q <= '0;
            r_idx_q <= '0;
            r_q_q   <= '0;
            r_w_q   <= 1'b0;
            r_z_q   <= 1'b0;
        end else begin
            r_acc_q <= r_acc_d;
            r_idx_q <= r_idx_d;
            r_q_q   <= r_q_d;
            r_w_q   <= r_w_d;
            r_z_q   <= r_z_d;
        end
    end

    always_comb begin
        r_acc_d = r_acc_q;
        r_idx_d = r_idx_q;
        r_q_d   = r_q_q;
        r_w_d   = r_w_q;
        r_z_d   = r_z_q;
        if (w_last) begin
            r_q_d   = {bus.d, r_acc_q[WIDTH-2:0]};
            r_acc_d = '0;
            r_idx_d = '0;
            r_w_d   = 1'b1;
            // A still-valid, unacknowledged word is being overwritten.
            if (r_w_q && !bus.ack) begin
                r_z_d = 1'b1;
            end
        end else begin
            if (bus.x) begin
                r_acc_d[r_idx_q] = bus.d;
                r_idx_d          = r_idx_q + CW'(1);
            end
            if (r_w_q && bus.ack) begin
                r_w_d = 1'b0;
            end
        end
    end

    assign bus.q     = r_q_q;
    assign bus.w     = r_w_q;
    assign bus.z     = r_z_q;
    assign bus.count = r_idx_q;
endmodule

// File: tb/tb_serial_word_capture.sv
// Directed self-checking bench for serial_word_capture (WIDTH = 32).
module tb_serial_word_capture;
    localparam int unsigned WIDTH = 32;

    logic clock;
    logic clear;
    int   n_cmp;
    int   n_bad;

    serial_word_capture_if #(.WIDTH(WIDTH)) bus ();

    serial_word_capture #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sends one word LSB first; optional idle cycle after each bit but the last,
    // optional ack asserted alongside the final bit.
    task automatic send_word(input logic [31:0] v, input bit gapped, input bit ack_last);
        for (int i = 0; i < 32; i++) begin
            bus.x   = 1'b1;
            bus.d   = v[i];
            bus.ack = (i == 31) ? ack_last : 1'b0;
            check("count_pre", 64'(bus.count), 64'(i));
            tick();
            bus.x   = 1'b0;
            bus.ack = 1'b0;
            if (gapped && i != 31) begin
                tick();
                check("count_hold", 64'(bus.count), 64'(i + 1));
            end
        end
        check("count_wrap", 64'(bus.count), 64'd0);
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        bus.x   = 1'b0;
        bus.d   = 1'b0;
        bus.ack = 1'b0;

        // Reset with x active and d toggling
        clear = 1'b1;
        bus.x = 1'b1;
        bus.d = 1'b1;
        tick();
        bus.d = 1'b0;
        tick();
        clear = 1'b0;
        bus.x = 1'b0;
        check("rst_q", 64'(bus.q), 64'h0);
        check("rst_w", 64'(bus.w), 64'd0);
        check("rst_z", 64'(bus.z), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);

        // Continuous stream
        send_word(32'hA5C30F01, 1'b0, 1'b0);
        check("cont_q", 64'(bus.q), 64'hA5C30F01);
        check("cont_w", 64'(bus.w), 64'd1);
        check("cont_z", 64'(bus.z), 64'd0);

        // Ack pulse clears w and retains q
        ack_pulse();
        check("ack_w", 64'(bus.w), 64'd0);
        check("ack_q", 64'(bus.q), 64'hA5C30F01);

        // Gapped stream
        send_word(32'hA5C30F01, 1'b1, 1'b0);
        check("gap_q", 64'(bus.q), 64'hA5C30F01);
        check("gap_w", 64'(bus.w), 64'd1);
        check("gap_z", 64'(bus.z), 64'd0);
        ack_pulse();
        check("gap_ack_w", 64'(bus.w), 64'd0);

        // Overrun
        send_word(32'h0000FFFF, 1'b0, 1'b0);
        check("ffff_q", 64'(bus.q), 64'h0000FFFF);
        check("ffff_z", 64'(bus.z), 64'd0);
        send_word(32'h12345678, 1'b0, 1'b0);
        check("ovr_q", 64'(bus.q), 64'h12345678);
        check("ovr_w", 64'(bus.w), 64'd1);
        check("ovr_z", 64'(bus.z), 64'd1);
        ack_pulse();
        check("ovr_ack_w", 64'(bus.w), 64'd0);
        check("ovr_ack_z", 64'(bus.z), 64'd1);
        ack_pulse();
        check("idle_ack_w", 64'(bus.w), 64'd0);
        check("idle_ack_z", 64'(bus.z), 64'd1);
        check("idle_ack_q", 64'(bus.q), 64'h12345678);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_z", 64'(bus.z), 64'd0);

        // Ack coincident with completion while the previous word is valid
        send_word(32'h0000FFFF, 1'b0, 1'b0);
        check("pre_sim_w", 64'(bus.w), 64'd1);
        send_word(32'hDEADBEEF, 1'b0, 1'b1);
        check("sim_q", 64'(bus.q), 64'hDEADBEEF);
        check("sim_w", 64'(bus.w), 64'd1);
        check("sim_z", 64'(bus.z), 64'd0);

        // Clear mid-word
        for (int i = 0; i < 17; i++) begin
            bus.x = 1'b1;
            bus.d = 1'b1;
            tick();
        end
        bus.x = 1'b0;
        check("mid_count", 64'(bus.count), 64'd17);
        check("mid_q_hidden", 64'(bus.q), 64'hDEADBEEF);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("mclr_count", 64'(bus.count), 64'd0);
        check("mclr_q", 64'(bus.q), 64'h0);
        check("mclr_w", 64'(bus.w), 64'd0);
        send_word(32'h80000001, 1'b0, 1'b0);
        check("post_q", 64'(bus.q), 64'h80000001);
        check("post_w", 64'(bus.w), 64'd1);
        check("post_z", 64'(bus.z), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
